// File: rtl/chunked_bla_subtractor_pkg.sv
// Shared types and helpers for the chunked borrow-lookahead subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int sub_width(input int n, input int words);
    return n * words;
  endfunction

endpackage

// File: rtl/chunked_bla_subtractor_if.sv
// Operand/result handshake bundle for chunked_bla_subtractor.
// The master side drives operands and accepts results; the slave side is the subtractor.
interface chunked_bla_subtractor_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
) ();
  import sub_pkg::*;

  localparam int W = sub_width(N, WORDS);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );

endinterface

// File: rtl/chunked_bla_subtractor_bla.sv
// Combinational N-bit borrow-lookahead subtract slice: d = x - y - bi, bo = borrow out.
module bla_subtractor #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bi,
  output logic [N-1:0] d,
  output logic         bo
);

  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N-1:0] grp_g_s;
  logic [N-1:0] grp_p_s;
  logic [N:0]   br_s;

  // Prefix group generate/propagate so every borrow is a direct function of bi.
  always_comb begin
    g_s     = ~x & y;
    p_s     = ~(x ^ y);
    grp_g_s = {N{1'b0}};
    grp_p_s = {N{1'b0}};
    br_s    = {(N + 1){1'b0}};
    br_s[0] = bi;
    grp_g_s[0] = g_s[0];
    grp_p_s[0] = p_s[0];
    for (int i = 1; i < N; i++) begin
      grp_g_s[i] = g_s[i] | (p_s[i] & grp_g_s[i-1]);
      grp_p_s[i] = p_s[i] & grp_p_s[i-1];
    end
    for (int i = 0; i < N; i++) begin
      br_s[i+1] = grp_g_s[i] | (grp_p_s[i] & bi);
    end
    d  = x ^ y ^ br_s[N-1:0];
    bo = br_s[N];
  end

endmodule

// File: rtl/chunked_bla_subtractor.sv
// Multi-cycle wide subtractor: a - b - bin over N*WORDS bits, one chunk per clock.
// Zero/overflow flag logic is built only when SUB_FLAGS_EN is defined.
import sub_pkg::*;

module chunked_bla_subtractor #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  chunked_bla_subtractor_if.slave bus
);

  localparam int W  = sub_width(N, WORDS);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  state_e        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  diff_q;
  logic [IW-1:0] idx_q;
  logic          borrow_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          bout_q;

  logic [N-1:0]  x_s;
  logic [N-1:0]  y_s;
  logic [N-1:0]  d_s;
  logic          bo_s;
  logic          accept_s;
  logic          last_s;

  // Steer the active chunk of the captured operands into the shared slice.
  always_comb begin
    x_s      = a_q[int'(idx_q) * N +: N];
    y_s      = b_q[int'(idx_q) * N +: N];
    accept_s = (state_q == IDLE) && bus.in_valid && in_ready_q;
    last_s   = (idx_q == IDX_LAST);
  end

  bla_subtractor #(.N(N)) u_slice (
    .x  (x_s),
    .y  (y_s),
    .bi (borrow_q),
    .d  (d_s),
    .bo (bo_s)
  );

`ifdef SUB_FLAGS_EN
  logic [W-1:0] diff_done_s;
  logic         zero_q;
  logic         ovf_q;

  // Full result as it will stand once the final chunk lands, for the flags.
  always_comb begin
    diff_done_s = diff_q;
    diff_done_s[int'(idx_q) * N +: N] = d_s;
  end
`endif

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      diff_q      <= {W{1'b0}};
      idx_q       <= {IW{1'b0}};
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bout_q      <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            borrow_q   <= bus.bin;
            idx_q      <= {IW{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          diff_q[int'(idx_q) * N +: N] <= d_s;
          borrow_q <= bo_s;
          if (last_s) begin
            idx_q       <= {IW{1'b0}};
            bout_q      <= bo_s;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SUB_FLAGS_EN
            zero_q <= (diff_done_s == {W{1'b0}});
            ovf_q  <= (a_q[W-1] != b_q[W-1]) && (diff_done_s[W-1] != a_q[W-1]);
`endif
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SUB_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`else
  assign bus.zero      = 1'b0;
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_bla_subtractor.sv
// Randomized self-checking bench for chunked_bla_subtractor against an integer-arithmetic model.
module tb_chunked_bla_subtractor;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  chunked_bla_subtractor_if #(.N(N), .WORDS(WORDS)) bus ();

  chunked_bla_subtractor #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, signed range check for overflow.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       output logic [15:0] d, output logic bo, output logic z, output logic v);
    int full;
    int sres;
    full = int'(a) - int'(b) - int'(bi);
    sres = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d    = full[15:0];
    bo   = (full < 0);
`ifdef SUB_FLAGS_EN
    z    = (d == 16'h0000);
    v    = (sres > 32767) || (sres < -32768);
`else
    z    = 1'b0;
    v    = 1'b0;
`endif
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi, input int hold);
    logic [15:0] ed;
    logic        eb;
    logic        ez;
    logic        ev;
    int          lat;
    bit          seen;
    model(a, b, bi, ed, eb, ez, ev);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.bin = bi; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("latency", 32'(lat), 32'(WORDS));
    check_eq("diff", 32'(bus.diff), 32'(ed));
    check_eq("bout", 32'(bus.bout), 32'(eb));
    check_eq("zero", 32'(bus.zero), 32'(ez));
    check_eq("ovf", 32'(bus.ovf), 32'(ev));
    check_eq("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'($urandom);
      @(posedge clk); #1;
      check_eq("hold_diff", 32'(bus.diff), 32'(ed));
      check_eq("hold_bout", 32'(bus.bout), 32'(eb));
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("release_valid", 32'(bus.out_valid), 32'd0);
    check_eq("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_diff", 32'(bus.diff), 32'd0);
    check_eq("rst_bout", 32'(bus.bout), 32'd0);
    check_eq("rst_zero", 32'(bus.zero), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 2);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h0005, 16'h0004, 1'b1, 10);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1);

    // Abandon an operation mid-RUN with idx at 2.
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h0222; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("midrst_diff", 32'(bus.diff), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check_eq("midrst_no_pulse", 32'(pulses), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
